// File: rtl/fmc_core_selector.sv
// FMC address decoder and read-data mux behind the arbiter.
// Routes accesses to external cores or the board register bank.
module fmc_core_selector #(
  parameter int          NUM_CORES     = 4,
  parameter logic [31:0] BOARD_NAME0   = 32'h50565431,
  parameter logic [31:0] BOARD_NAME1   = 32'h20202020,
  parameter logic [31:0] BOARD_VERSION = 32'h00000001,
  parameter logic [31:0] UNMAPPED_DATA = 32'hDEADBEEF
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [21:0]             sys_fmc_addr,
  input  logic                    sys_fmc_wren,
  input  logic                    sys_fmc_rden,
  input  logic [31:0]             sys_fmc_dout,
  output logic [31:0]             sys_fmc_din,
  output logic [NUM_CORES-1:0]    core_cs,
  output logic                    core_we,
  output logic [7:0]              core_addr,
  output logic [31:0]             core_write_data,
  input  logic [32*NUM_CORES-1:0] core_read_data
);

  localparam logic [7:0] NC = 8'(NUM_CORES);

  logic [7:0]  seg;
  logic [7:0]  rga;
  logic        hi_ok;
  logic        strobe;
  logic        is_rd;
  logic        is_both;
  logic        core_hit;
  logic        brd_hit;
  logic [NUM_CORES-1:0] cs_nxt;

  logic        s1_vld;
  logic        s1_rd;
  logic        s1_wr;
  logic        s1_err;
  logic        s1_brd;
  logic [7:0]  s1_reg;

  logic [31:0] scratch;
  logic [31:0] acc_cnt;
  logic [31:0] unm_cnt;
  logic [31:0] core_dat;
  logic [31:0] brd_val;
  logic [31:0] rd_mux;
  logic        core_sel;

  assign seg      = sys_fmc_addr[15:8];
  assign rga      = sys_fmc_addr[7:0];
  assign hi_ok    = (sys_fmc_addr[21:16] == 6'd0);
  assign strobe   = sys_fmc_wren | sys_fmc_rden;
  assign is_rd    = sys_fmc_rden & ~sys_fmc_wren;
  assign is_both  = sys_fmc_rden & sys_fmc_wren;
  assign core_hit = strobe & hi_ok & (seg != 8'd0) & (seg <= NC);
  assign brd_hit  = strobe & hi_ok & (seg == 8'd0) & (rga <= 8'd5);

  always_comb begin
    cs_nxt = '0;
    for (int k = 0; k < NUM_CORES; k++)
      cs_nxt[k] = core_hit && (seg == 8'(k + 1));
  end

  always_comb begin
    core_dat = '0;
    for (int k = 0; k < NUM_CORES; k++)
      if (core_cs[k])
        core_dat = core_dat | core_read_data[32*k +: 32];
  end

  assign core_sel = |core_cs;

  always_comb begin
    brd_val = UNMAPPED_DATA;
    case (s1_reg)
      8'h00:   brd_val = BOARD_NAME0;
      8'h01:   brd_val = BOARD_NAME1;
      8'h02:   brd_val = BOARD_VERSION;
      8'h03:   brd_val = scratch;
      8'h04:   brd_val = acc_cnt;
      8'h05:   brd_val = unm_cnt;
      default: brd_val = UNMAPPED_DATA;
    endcase
  end

  always_comb begin
    rd_mux = UNMAPPED_DATA;
    unique case (1'b1)
      core_sel: rd_mux = core_dat;
      s1_brd:   rd_mux = brd_val;
      default:  rd_mux = UNMAPPED_DATA;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      core_cs         <= '0;
      core_we         <= 1'b0;
      core_addr       <= '0;
      core_write_data <= '0;
      s1_vld          <= 1'b0;
      s1_rd           <= 1'b0;
      s1_wr           <= 1'b0;
      s1_err          <= 1'b0;
      s1_brd          <= 1'b0;
      s1_reg          <= '0;
      scratch         <= '0;
      acc_cnt         <= '0;
      unm_cnt         <= '0;
      sys_fmc_din     <= '0;
    end else begin
      core_cs <= cs_nxt;
      core_we <= sys_fmc_wren & core_hit;
      if (core_hit) begin
        core_addr       <= rga;
        core_write_data <= sys_fmc_dout;
      end
      s1_vld <= strobe;
      s1_rd  <= is_rd;
      s1_wr  <= sys_fmc_wren;
      s1_err <= is_both | (strobe & ~core_hit & ~brd_hit);
      s1_brd <= brd_hit;
      s1_reg <= rga;
      if (sys_fmc_wren && brd_hit && rga == 8'h03)
        scratch <= sys_fmc_dout;
      // Counters run one stage late so a clear beats its own increment
      if (s1_wr && s1_brd && s1_reg == 8'h04)
        acc_cnt <= '0;
      else if (s1_vld)
        acc_cnt <= acc_cnt + 32'd1;
      if (s1_wr && s1_brd && s1_reg == 8'h05)
        unm_cnt <= '0;
      else if (s1_err && unm_cnt != 32'hFFFFFFFF)
        unm_cnt <= unm_cnt + 32'd1;
      if (s1_rd)
        sys_fmc_din <= rd_mux;
    end
  end

endmodule

// File: tb/tb_fmc_core_selector.sv
// Directed bench for fmc_core_selector.
// Expected values are hand-computed per vector.
module tb_fmc_core_selector;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n;
  logic [21:0]  sys_fmc_addr;
  logic         sys_fmc_wren;
  logic         sys_fmc_rden;
  logic [31:0]  sys_fmc_dout;
  logic [31:0]  sys_fmc_din;
  logic [3:0]   core_cs;
  logic         core_we;
  logic [7:0]   core_addr;
  logic [31:0]  core_write_data;
  logic [127:0] core_read_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_din;

  assign core_read_data = {32'hCAFE0003, 32'hCAFE0002,
                           32'hCAFE0001, 32'hCAFE0000};

  always #5 sys_clk = ~sys_clk;

  fmc_core_selector dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .sys_fmc_addr    (sys_fmc_addr),
    .sys_fmc_wren    (sys_fmc_wren),
    .sys_fmc_rden    (sys_fmc_rden),
    .sys_fmc_dout    (sys_fmc_dout),
    .sys_fmc_din     (sys_fmc_din),
    .core_cs         (core_cs),
    .core_we         (core_we),
    .core_addr       (core_addr),
    .core_write_data (core_write_data),
    .core_read_data  (core_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle();
    sys_fmc_wren = 1'b0;
    sys_fmc_rden = 1'b0;
  endtask

  // Returns in cycle T+1
  task automatic wr(input logic [21:0] a, input logic [31:0] d);
    sys_fmc_addr = a;
    sys_fmc_dout = d;
    sys_fmc_wren = 1'b1;
    sys_fmc_rden = 1'b0;
    tick();
    idle();
  endtask

  task automatic rd(input string tag, input logic [21:0] a,
                    input logic [31:0] exp);
    sys_fmc_addr = a;
    sys_fmc_rden = 1'b1;
    sys_fmc_wren = 1'b0;
    tick();
    idle();
    chk({tag, "_t1"}, sys_fmc_din, last_din);
    tick();
    chk(tag, sys_fmc_din, exp);
    last_din = exp;
  endtask

  initial begin
    sys_rst_n    = 1'b0;
    sys_fmc_addr = '0;
    sys_fmc_dout = '0;
    idle();
    last_din = '0;
    repeat (3) tick();
    chk("rst_din", sys_fmc_din, 32'h0);
    chk("rst_cs", 32'(core_cs), 32'h0);
    chk("rst_we", 32'(core_we), 32'h0);
    chk("rst_addr", 32'(core_addr), 32'h0);
    chk("rst_wdata", core_write_data, 32'h0);
    sys_rst_n = 1'b1;
    tick();

    rd("name0", 22'h000000, 32'h50565431);
    rd("name1", 22'h000001, 32'h20202020);
    rd("ver", 22'h000002, 32'h00000001);
    rd("acc4", 22'h000004, 32'h00000003);

    wr(22'h000003, 32'hA5A55A5A);
    rd("scratch", 22'h000003, 32'hA5A55A5A);
    wr(22'h000001, 32'hFFFFFFFF);
    rd("name1_ro", 22'h000001, 32'h20202020);

    wr(22'h000310, 32'h12345678);
    chk("wr_cs", 32'(core_cs), 32'h4);
    chk("wr_we", 32'(core_we), 32'h1);
    chk("wr_addr", 32'(core_addr), 32'h10);
    chk("wr_wdata", core_write_data, 32'h12345678);
    tick();
    chk("wr_cs_pulse", 32'(core_cs), 32'h0);
    sys_fmc_addr = 22'h000310;
    sys_fmc_rden = 1'b1;
    tick();
    idle();
    chk("rdc_cs", 32'(core_cs), 32'h4);
    chk("rdc_we", 32'(core_we), 32'h0);
    tick();
    chk("rdc_din", sys_fmc_din, 32'hCAFE0002);
    last_din = 32'hCAFE0002;

    sys_fmc_addr = 22'h000500;
    sys_fmc_rden = 1'b1;
    tick();
    idle();
    chk("um_seg_cs", 32'(core_cs), 32'h0);
    tick();
    chk("um_seg", sys_fmc_din, 32'hDEADBEEF);
    last_din = 32'hDEADBEEF;
    sys_fmc_addr = 22'h010000;
    sys_fmc_rden = 1'b1;
    tick();
    idle();
    chk("um_hi_cs", 32'(core_cs), 32'h0);
    tick();
    chk("um_hi", sys_fmc_din, 32'hDEADBEEF);
    rd("um_brd", 22'h000007, 32'hDEADBEEF);
    rd("unm3", 22'h000005, 32'h00000003);
    wr(22'h000005, 32'h0);
    rd("unm_clr", 22'h000005, 32'h00000000);

    rd("acc16", 22'h000004, 32'd16);
    wr(22'h000004, 32'h55);
    rd("acc_clr", 22'h000004, 32'h00000000);

    sys_fmc_addr = 22'h000003;
    sys_fmc_dout = 32'h1;
    sys_fmc_wren = 1'b1;
    sys_fmc_rden = 1'b1;
    tick();
    idle();
    tick();
    chk("both_din", sys_fmc_din, last_din);
    rd("both_scr", 22'h000003, 32'h00000001);
    rd("both_unm", 22'h000005, 32'h00000001);

    sys_fmc_rden = 1'b1;
    sys_fmc_addr = 22'h000100;
    tick();
    sys_fmc_addr = 22'h000200;
    chk("b2b_cs1", 32'(core_cs), 32'h1);
    tick();
    sys_fmc_addr = 22'h000300;
    chk("b2b_cs2", 32'(core_cs), 32'h2);
    chk("b2b_rd1", sys_fmc_din, 32'hCAFE0000);
    tick();
    sys_fmc_addr = 22'h000400;
    sys_rst_n    = 1'b0;
    chk("b2b_cs3", 32'(core_cs), 32'h4);
    chk("b2b_rd2", sys_fmc_din, 32'hCAFE0001);
    tick();
    idle();
    sys_rst_n = 1'b1;
    chk("r2_din", sys_fmc_din, 32'h0);
    chk("r2_cs", 32'(core_cs), 32'h0);
    chk("r2_we", 32'(core_we), 32'h0);
    chk("r2_addr", 32'(core_addr), 32'h0);
    chk("r2_wdata", core_write_data, 32'h0);
    tick();
    chk("r2_no_cs4", 32'(core_cs), 32'h0);
    chk("r2_din2", sys_fmc_din, 32'h0);
    last_din = '0;
    rd("r2_scr", 22'h000003, 32'h0);
    rd("r2_acc", 22'h000004, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
